// File: rtl/mc6502_dma_pkg.sv
// Shared types and default addresses for the 6502 sprite-page DMA controller.
package mc6502_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_ALIGN     = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4
  } state_t;

  localparam logic [15:0] DEF_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DEF_DEST_ADDR    = 16'h2004;

endpackage

// File: rtl/mc6502_dma_controller_if.sv
// CPU-side and memory-side bus signals of the DMA controller.
// Handshake: cpu_rdy high means the CPU owns the bus this cycle; while it is
// low (and the CPU is on a read) the controller drives bus_ab/bus_rw/bus_db_w.
interface mc6502_dma_controller_if;

  logic [15:0] cpu_ab;
  logic [7:0]  cpu_db_w;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [7:0]  cpu_db_r;
  logic [15:0] bus_ab;
  logic [7:0]  bus_db_w;
  logic        bus_rw;
  logic [7:0]  bus_db_r;

  // controller view
  modport slave (
    input  cpu_ab, cpu_db_w, cpu_rw, bus_db_r,
    output cpu_rdy, cpu_db_r, bus_ab, bus_db_w, bus_rw
  );

  // CPU + memory view
  modport master (
    output cpu_ab, cpu_db_w, cpu_rw, bus_db_r,
    input  cpu_rdy, cpu_db_r, bus_ab, bus_db_w, bus_rw
  );

endinterface

// File: rtl/mc6502_dma_controller.sv
// Bus arbiter and 256-byte page-copy DMA sequencer between a 6502 core and memory.
// Transparent pass-through when idle; stalls the CPU via RDY during a transfer.
module mc6502_dma_controller
  import mc6502_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
  parameter logic [15:0] DEST_ADDR    = DEF_DEST_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  mc6502_dma_controller_if.slave      bus,
  output logic                        dma_busy,
  output logic                        dma_done,
  output state_t                      dbg_state
);

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic        odd;
  logic        rdy_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
      odd    <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      odd    <= ~odd;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.cpu_rw && bus.cpu_ab == TRIGGER_ADDR) begin
            page   <= bus.cpu_db_w;
            idx    <= 8'h00;
            state  <= ST_HALT_WAIT;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        // The 6502 ignores RDY on writes, so only a read cycle actually halts it.
        // READ must land on an even cycle; insert ALIGN when it would not.
        ST_HALT_WAIT: begin
          if (bus.cpu_rw) begin
            state <= odd ? ST_READ : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          state <= ST_READ;
        end
        ST_READ: begin
          data   <= bus.bus_db_r;
          state  <= ST_WRITE;
          done_q <= (idx == 8'hFF);
        end
        ST_WRITE: begin
          idx <= idx + 8'h01;
          if (idx == 8'hFF) begin
            state  <= ST_IDLE;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state <= ST_READ;
          end
        end
        default: begin
          state  <= ST_IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.bus_ab   = bus.cpu_ab;
    bus.bus_rw   = bus.cpu_rw;
    bus.bus_db_w = bus.cpu_db_w;
    case (state)
      ST_READ: begin
        bus.bus_ab = {page, idx};
        bus.bus_rw = 1'b1;
      end
      ST_WRITE: begin
        bus.bus_ab   = DEST_ADDR;
        bus.bus_rw   = 1'b0;
        bus.bus_db_w = data;
      end
      default: ;
    endcase
  end

  assign bus.cpu_db_r = bus.bus_db_r;
  assign bus.cpu_rdy  = rdy_q;
  assign dma_busy     = busy_q;
  assign dma_done     = done_q;
  assign dbg_state    = state;

endmodule
